// File: rtl/life_frame_scanner.sv
// life_frame_scanner: walks the sixteen 4x4 blocks of a 16x16 Life array,
// accumulating the live-cell count and a "nothing changed" flag, then
// publishes per-frame statistics (population, extinction, stillness,
// still-run length and generation count) in a single DONE cycle.
module life_frame_scanner (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  host_selector,
  input  logic [15:0] valo,
  input  logic [15:0] valo_prev,
  output logic [3:0]  valo_selector,
  output logic        busy,
  output logic        done,
  output logic        frame_valid,
  output logic [8:0]  population,
  output logic        extinct,
  output logic        still,
  output logic [7:0]  still_run,
  output logic [15:0] generation
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of live cells in one 4x4 block.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

  // Saturating increment used for the still-run counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'd255) begin
      r = 8'd255;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  index_r;
  logic [8:0]  acc_r;
  logic        still_acc_r;

  logic        load_s;
  logic        step_s;
  logic        finish_s;
  logic [8:0]  acc_sum_s;
  logic        still_sum_s;

  logic        busy_r;
  logic        done_r;
  logic        frame_valid_r;
  logic [8:0]  population_r;
  logic        extinct_r;
  logic        still_r;
  logic [7:0]  still_run_r;
  logic [15:0] generation_r;

  // Running totals including the block currently on the valo bus; these are
  // what the accumulators and, on the last block, the results take.
  always_comb begin
    acc_sum_s   = acc_r + {4'd0, popcount16(valo)};
    still_sum_s = still_acc_r & (valo == valo_prev);
  end

  // Next-state decode and block-select mux; the host owns the array only
  // while idle, the scanner owns it for the whole busy window.
  always_comb begin
    state_s       = state_r;
    valo_selector = host_selector;
    load_s        = 1'b0;
    step_s        = 1'b0;
    finish_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        valo_selector = host_selector;
        if (start) begin
          state_s = ST_SCAN;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        valo_selector = index_r;
        step_s        = 1'b1;
        if (index_r == 4'd15) begin
          state_s  = ST_DONE;
          finish_s = 1'b1;
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_DONE: begin
        valo_selector = index_r;
        state_s       = ST_IDLE;
      end
      default: begin
        valo_selector = host_selector;
        state_s       = ST_IDLE;
      end
    endcase
  end

  // State register plus the busy/done flags, both derived from the next state
  // so they line up with the SCAN/DONE cycles themselves.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= finish_s;
    end
  end

  // Block index and partial-frame accumulators; never routed to outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      index_r     <= 4'd0;
      acc_r       <= 9'd0;
      still_acc_r <= 1'b0;
    end else if (load_s) begin
      index_r     <= 4'd0;
      acc_r       <= 9'd0;
      still_acc_r <= 1'b1;
    end else if (step_s) begin
      index_r     <= index_r + 4'd1;
      acc_r       <= acc_sum_s;
      still_acc_r <= still_sum_s;
    end
  end

  // Frame results: updated only on the edge that consumes the last block,
  // so an aborted scan never disturbs them beyond what reset clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_valid_r <= 1'b0;
      population_r  <= 9'd0;
      extinct_r     <= 1'b0;
      still_r       <= 1'b0;
    end else if (finish_s) begin
      frame_valid_r <= 1'b1;
      population_r  <= acc_sum_s;
      extinct_r     <= (acc_sum_s == 9'd0);
      still_r       <= still_sum_s;
    end
  end

  // Frame history counters: still-run saturates, generation wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      still_run_r  <= 8'd0;
      generation_r <= 16'd0;
    end else if (finish_s) begin
      still_run_r  <= still_sum_s ? sat_inc8(still_run_r) : 8'd0;
      generation_r <= generation_r + 16'd1;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign frame_valid = frame_valid_r;
  assign population  = population_r;
  assign extinct     = extinct_r;
  assign still       = still_r;
  assign still_run   = still_run_r;
  assign generation  = generation_r;

endmodule

// File: tb/tb_life_frame_scanner.sv
// Directed bench for life_frame_scanner; a small array model answers the
// block selector combinationally and all expectations are hand-computed.
module tb_life_frame_scanner;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  host_selector;
  logic [15:0] valo;
  logic [15:0] valo_prev;
  logic [3:0]  valo_selector;
  logic        busy;
  logic        done;
  logic        frame_valid;
  logic [8:0]  population;
  logic        extinct;
  logic        still;
  logic [7:0]  still_run;
  logic [15:0] generation;

  logic [15:0] cur_m  [16];
  logic [15:0] prev_m [16];

  int n_checks;
  int n_errors;

  life_frame_scanner dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .host_selector (host_selector),
    .valo          (valo),
    .valo_prev     (valo_prev),
    .valo_selector (valo_selector),
    .busy          (busy),
    .done          (done),
    .frame_valid   (frame_valid),
    .population    (population),
    .extinct       (extinct),
    .still         (still),
    .still_run     (still_run),
    .generation    (generation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign valo      = cur_m[valo_selector];
  assign valo_prev = prev_m[valo_selector];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_array();
    for (int i = 0; i < 16; i++) begin
      cur_m[i]  = 16'h0000;
      prev_m[i] = 16'h0000;
    end
  endtask

  // Pulse start for one edge, walk the 16 SCAN cycles, return in the DONE cycle.
  task automatic run_scan(input bit trace);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (trace) begin
        if (c <= 16) check_val("scan_sel", 32'(valo_selector), 32'(c - 1));
        check_val("scan_done", 32'(done), 32'(c == 17));
        check_val("scan_busy", 32'(busy), 32'd1);
      end
      if (c < 17) tick();
    end
  endtask

  int done_cnt;
  int done_cyc [2];
  int sel_errs;
  int phase;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    start         = 1'b0;
    host_selector = 4'h3;
    clear_array();
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_fv", 32'(frame_valid), 32'd0);
    check_val("rst_pop", 32'(population), 32'd0);
    check_val("rst_ext", 32'(extinct), 32'd0);
    check_val("rst_still", 32'(still), 32'd0);
    check_val("rst_run", 32'(still_run), 32'd0);
    check_val("rst_gen", 32'(generation), 32'd0);
    check_val("rst_sel", 32'(valo_selector), 32'h3);

    // Empty array: one traced scan
    run_scan(1'b1);
    check_val("z_pop", 32'(population), 32'd0);
    check_val("z_ext", 32'(extinct), 32'd1);
    check_val("z_still", 32'(still), 32'd1);
    check_val("z_run", 32'(still_run), 32'd1);
    check_val("z_gen", 32'(generation), 32'd1);
    check_val("z_fv", 32'(frame_valid), 32'd1);
    tick();
    check_val("z_idle_busy", 32'(busy), 32'd0);
    check_val("z_idle_done", 32'(done), 32'd0);
    check_val("z_idle_sel", 32'(valo_selector), 32'h3);
    check_val("z_hold_gen", 32'(generation), 32'd1);

    // Two still scans with 18 live cells
    do_reset();
    check_val("r2_fv", 32'(frame_valid), 32'd0);
    cur_m[5]   = 16'hEEE0;
    prev_m[5]  = 16'hEEE0;
    cur_m[10]  = 16'h0777;
    prev_m[10] = 16'h0777;
    run_scan(1'b0);
    tick();
    run_scan(1'b1);
    check_val("p18_pop", 32'(population), 32'd18);
    check_val("p18_ext", 32'(extinct), 32'd0);
    check_val("p18_still", 32'(still), 32'd1);
    check_val("p18_run", 32'(still_run), 32'd2);
    check_val("p18_gen", 32'(generation), 32'd2);
    tick();

    // Changed block after still scans
    clear_array();
    cur_m[6]  = 16'h0111;
    prev_m[6] = 16'h0300;
    run_scan(1'b1);
    check_val("chg_pop", 32'(population), 32'd3);
    check_val("chg_still", 32'(still), 32'd0);
    check_val("chg_run", 32'(still_run), 32'd0);
    check_val("chg_ext", 32'(extinct), 32'd0);
    check_val("chg_gen", 32'(generation), 32'd3);
    tick();
    check_val("chg_hold_pop", 32'(population), 32'd3);

    // Host selector pass-through, then start held high for 40 cycles
    host_selector = 4'h9;
    #1;
    check_val("host_sel9", 32'(valo_selector), 32'h9);
    done_cnt = 0;
    sel_errs = 0;
    done_cyc[0] = 0;
    done_cyc[1] = 0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      phase = i % 18;
      if (done) begin
        if (done_cnt < 2) done_cyc[done_cnt] = i + 1;
        done_cnt++;
      end
      if (phase < 16 && valo_selector !== 4'(phase)) sel_errs++;
      if (phase == 17 && valo_selector !== 4'h9) sel_errs++;
      if (done !== (phase == 16)) sel_errs++;
    end
    start = 1'b0;
    check_val("held_done_cnt", 32'(done_cnt), 32'd2);
    check_val("held_done_1st", 32'(done_cyc[0]), 32'd17);
    check_val("held_done_2nd", 32'(done_cyc[1]), 32'd35);
    check_val("held_sel_errs", 32'(sel_errs), 32'd0);
    check_val("held_gen", 32'(generation), 32'd5);

    // Third scan is in flight (index 3); move to index 7 and abort with reset
    for (int i = 0; i < 4; i++) tick();
    check_val("abort_sel7", 32'(valo_selector), 32'h7);
    check_val("abort_busy_pre", 32'(busy), 32'd1);
    do_reset();
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_fv", 32'(frame_valid), 32'd0);
    check_val("abort_pop", 32'(population), 32'd0);
    check_val("abort_still", 32'(still), 32'd0);
    check_val("abort_run", 32'(still_run), 32'd0);
    check_val("abort_gen", 32'(generation), 32'd0);
    check_val("abort_sel", 32'(valo_selector), 32'h9);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    check_val("abort_quiet", 32'(done_cnt), 32'd0);

    // Saturation of still_run and wrap of generation
    clear_array();
    host_selector = 4'h2;
    for (int k = 0; k < 256; k++) begin
      run_scan(1'b0);
      tick();
    end
    check_val("sat_run", 32'(still_run), 32'd255);
    check_val("sat_gen", 32'(generation), 32'd256);
    force dut.generation_r = 16'hFFFF;
    tick();
    release dut.generation_r;
    #1;
    check_val("bd_gen", 32'(generation), 32'hFFFF);
    run_scan(1'b1);
    check_val("wrap_gen", 32'(generation), 32'h0000);
    check_val("wrap_run", 32'(still_run), 32'd255);
    check_val("wrap_still", 32'(still), 32'd1);
    tick();
    prev_m[0] = 16'h0001;
    run_scan(1'b0);
    check_val("post_run", 32'(still_run), 32'd0);
    check_val("post_gen", 32'(generation), 32'd1);
    check_val("post_ext", 32'(extinct), 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/life_frame_scanner.md
LIFE_FRAME_SCANNER -- requirements
Module: life_frame_scanner

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request one full scan of the 16x16 array; sampled only in IDLE.
REQ-004 SHALL have port host_selector  input  4  block select passed through to the array while IDLE.
REQ-005 SHALL have port valo  input  16  current-generation cells of the selected 4x4 block, combinational from valo_selector.
REQ-006 SHALL have port valo_prev  input  16  previous-generation cells of the selected block, same timing as valo.
REQ-007 SHALL have port valo_selector  output  4  block select driven to the array.
REQ-008 SHALL have port busy  output  1  high in SCAN and DONE states.
REQ-009 SHALL have port done  output  1  one-cycle pulse when scan results update.
REQ-010 SHALL have port frame_valid  output  1  high once at least one scan has completed since reset.
REQ-011 SHALL have port population  output  9  live-cell count of last scan, 0..256.
REQ-012 SHALL have port extinct  output  1  last scan population == 0.
REQ-013 SHALL have port still  output  1  last scan had valo == valo_prev for all 16 blocks.
REQ-014 SHALL have port still_run  output  8  consecutive scans with still=1, saturating.
REQ-015 SHALL have port generation  output  16  count of completed scans, wraps.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-017 SHALL move IDLE->SCAN on the edge where start=1; index register loaded 0.
REQ-018 In SCAN, SHALL drive valo_selector = index; each edge: accumulate popcount(valo), AND-accumulate (valo==valo_prev), increment index.
REQ-019 SHALL move SCAN->DONE on the edge that samples index 15; exactly 16 SCAN cycles.
REQ-020 In DONE (one cycle), SHALL assert done, with population/extinct/still/still_run/generation/frame_valid already holding the new values; next edge -> IDLE.
REQ-021 Latency: done high in the 17th cycle after the start-sampling edge.
REQ-022 In IDLE, SHALL drive valo_selector = host_selector combinationally; in SCAN/DONE, host_selector ignored.
REQ-023 SHALL ignore start while busy; start held high re-triggers only from IDLE (back-to-back scan period 18 cycles).
REQ-024 Accumulator SHALL be 9 bits wide; 16 blocks x 16 cells = 256 max, no overflow.
REQ-025 still_run SHALL increment on a still scan, saturate at 255, clear to 0 on a non-still scan.
REQ-026 generation SHALL increment per completed scan, 0xFFFF -> 0x0000.
REQ-027 Output result registers SHALL hold between scans; partial-scan accumulators never visible on outputs.

Reset
REQ-028 reset=1 SHALL on the next edge force IDLE, index 0, accumulators 0, busy 0, done 0, frame_valid 0, population 0, extinct 0, still 0, still_run 0, generation 0.
REQ-029 reset SHALL override start and any in-progress scan; no done pulse for an aborted scan.
REQ-030 After reset, valo_selector SHALL equal host_selector (IDLE path).

Verification
REQ-031 All blocks valo=valo_prev=0, pulse start -> selector sequence 0..15, done in cycle 17, population 0, extinct 1, still 1, still_run 1, generation 1, frame_valid 1.
REQ-032 Block 5 = 0xEEE0, block A = 0x0777, prev identical, others 0; two scans -> population 18, extinct 0, still 1, still_run 2.
REQ-033 Block 6 valo=0x0111, valo_prev=0x0300, others 0, after a still scan -> population 3, still 0, still_run 0.
REQ-034 host_selector=4'h9 in IDLE -> valo_selector 9; start held high 40 cycles -> exactly two done pulses at cycles 17 and 35, valo_selector never 9 during SCAN.
REQ-035 reset asserted while index=7 -> next cycle busy 0, all outputs 0, valo_selector = host_selector, no done pulse.
REQ-036 Force generation to 0xFFFF and still_run to 255 via 65535 still scans (or backdoor) -> next still scan gives generation 0x0000, still_run 255.
